crc_msg_serializer: RTL and testbench

Upstream feeder for the two-level pipelined CRC stage. Accepts whole parallel message words over a valid/ready handshake. Builds the augmented message: the message followed by CRC_W zero bits, with zero padding at the front up to a multiple of LANES. Streams it MSB-first, LANES bits per beat, with start-of-frame and end-of-frame markers so the CRC stage can clear and capture its remainder. A one-entry pending buffer lets frames run back-to-back with no bubble.

---
 rtl/crc_msg_serializer_if.sv | 25 ++
 rtl/crc_msg_serializer.sv | 115 +++++++++++
 tb/tb_crc_msg_serializer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/crc_msg_serializer_if.sv
// Handshake bundle between the message source, the serializer and the CRC stage.
// The slave modport is the serializer's view; master is the environment's view.
interface crc_msg_serializer_if #(
    parameter int MSG_W = 10,
    parameter int LANES = 2
);
    logic [MSG_W-1:0] msg_in;
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] out_bits;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_eof;

    modport master (
        output msg_in, in_valid, out_ready,
        input  in_ready, out_bits, out_valid, out_sof, out_eof
    );

    modport slave (
        input  msg_in, in_valid, out_ready,
        output in_ready, out_bits, out_valid, out_sof, out_eof
    );
endinterface

// File: rtl/crc_msg_serializer.sv
// Serializes {pad zeros, message, CRC_W zeros} MSB-first, LANES bits per beat,
// with sof/eof framing; a one-word pending buffer allows back-to-back frames.
module crc_msg_serializer #(
    parameter int MSG_W = 10,
    parameter int CRC_W = 9,
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    crc_msg_serializer_if.slave   bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      frames_sent
);

    localparam int TOTAL = ((MSG_W + CRC_W + LANES - 1) / LANES) * LANES;
    localparam int BEATS = TOTAL / LANES;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [MSG_W-1:0]   pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic [TOTAL-1:0]   sr_q, sr_d;
    logic [BC_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]   frames_q, frames_d;

    logic [TOTAL-1:0]   load_img;
    logic               accept;
    logic               fire;
    logic               last_beat;
    logic               consume;

    // Leading pad bits stay zero so a zero-initialised CRC is unaffected.
    always_comb begin
        load_img = '0;
        load_img[CRC_W +: MSG_W] = pend_q;
    end

    assign accept    = bus.in_valid & ~pend_vld_q;
    assign fire      = (state_q == SHIFT) & bus.out_ready;
    assign last_beat = (beat_q == LAST_BEAT);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        beat_d   = beat_q;
        frames_d = frames_q;
        consume  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    sr_d    = load_img;
                    beat_d  = '0;
                    consume = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fire) begin
                    if (last_beat) begin
                        frames_d = frames_q + 1'b1;
                        beat_d   = '0;
                        // Reload in place so the next frame's sof follows eof directly.
                        if (pend_vld_q) begin
                            sr_d    = load_img;
                            consume = 1'b1;
                        end else begin
                            sr_d    = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        sr_d   = {sr_q[TOTAL-LANES-1:0], {LANES{1'b0}}};
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_vld_d = (pend_vld_q & ~consume) | accept;
        pend_d     = accept ? bus.msg_in : pend_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sr_q       <= '0;
            beat_q     <= '0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sr_q       <= sr_d;
            beat_q     <= beat_d;
            frames_q   <= frames_d;
        end
    end

    assign bus.in_ready  = ~pend_vld_q;
    assign bus.out_valid = (state_q == SHIFT);
    assign bus.out_bits  = bus.out_valid ? sr_q[TOTAL-1 -: LANES] : '0;
    assign bus.out_sof   = bus.out_valid & (beat_q == '0);
    assign bus.out_eof   = bus.out_valid & last_beat;
    assign busy          = (state_q == SHIFT) | pend_vld_q;
    assign frames_sent   = frames_q;

endmodule

// File: tb/tb_crc_msg_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed beats, a negedge monitor
// compares every presented beat (including held beats under backpressure).
module tb_crc_msg_serializer;

    localparam int MSG_W = 10;
    localparam int CRC_W = 9;
    localparam int LANES = 2;
    localparam int CNT_W = 2;

    localparam logic [MSG_W-1:0] M1 = 10'b1100000011;
    localparam logic [MSG_W-1:0] M2 = 10'b0000000001;
    localparam logic [MSG_W-1:0] M3 = 10'b1010101010;
    // Beat streams, beat 1 in the top two bits.
    localparam logic [19:0] E1 = 20'b01_10_00_00_01_10_00_00_00_00;
    localparam logic [19:0] E2 = 20'b00_00_00_00_00_10_00_00_00_00;
    localparam logic [19:0] E3 = 20'b01_01_01_01_01_00_00_00_00_00;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] frames_sent;

    always #5 clk = ~clk;

    crc_msg_serializer_if #(.MSG_W(MSG_W), .LANES(LANES)) bus ();

    crc_msg_serializer #(
        .MSG_W(MSG_W), .CRC_W(CRC_W), .LANES(LANES), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    typedef struct packed {
        logic [1:0] bits;
        logic       sof;
        logic       eof;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    errs    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.out_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_beat: got bits %b, expected no beat", bus.out_bits);
            end else begin
                check("beat_bits", 32'(bus.out_bits), 32'(sb[0].bits));
                check("beat_sof",  32'(bus.out_sof),  32'(sb[0].sof));
                check("beat_eof",  32'(bus.out_eof),  32'(sb[0].eof));
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic push_frame(input logic [19:0] e);
        beat_t b;
        for (int i = 0; i < 10; i++) begin
            b.bits = e[19-2*i -: 2];
            b.sof  = (i == 0);
            b.eof  = (i == 9);
            sb.push_back(b);
        end
    endtask

    task automatic send(input logic [MSG_W-1:0] m, input logic [19:0] e);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            guard++;
            @(posedge clk); #1;
        end
        if (!bus.in_ready) begin
            vectors++;
            errs++;
            $display("FAIL send_timeout: in_ready still 0, required 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.msg_in   = m;
        push_frame(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Runs until idle (or abort_at beats done), optionally stalling once.
    task automatic run(input int stall_at, input int stall_len, input int abort_at,
                       output int bcyc, output int vcyc);
        int fires = 0;
        int stalled = 0;
        int guard = 0;
        bcyc = 0;
        vcyc = 0;
        while (busy && guard < 200) begin
            if (fires == abort_at) break;
            guard++;
            if (fires == stall_at && stalled < stall_len && bus.out_valid) begin
                bus.out_ready = 1'b0;
                stalled++;
            end else begin
                bus.out_ready = 1'b1;
            end
            bcyc++;
            if (bus.out_valid) vcyc++;
            if (bus.out_valid && bus.out_ready) fires++;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        if (guard >= 200) begin
            vectors++;
            errs++;
            $display("FAIL run_timeout: busy still 1 after %0d cycles, required 0", guard);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_bits"},  32'(bus.out_bits),  0);
        check({tag, "_out_sof"},   32'(bus.out_sof),   0);
        check({tag, "_out_eof"},   32'(bus.out_eof),   0);
        check({tag, "_busy"},      32'(busy),          0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  1);
        check({tag, "_frames"},    32'(frames_sent),   0);
    endtask

    initial begin
        int bc, vc, guard;
        int exp_wrap[5] = '{1, 2, 3, 0, 1};
        bus.in_valid  = 1'b0;
        bus.msg_in    = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Single frame: one IDLE/pending cycle then 10 beats.
        send(M1, E1);
        check("single_busy_pend", 32'(busy), 1);
        check("single_in_ready_full", 32'(bus.in_ready), 0);
        run(-1, 0, -1, bc, vc);
        check("single_busy_cycles", bc, 11);
        check("single_valid_cycles", vc, 10);
        check("single_frames", 32'(frames_sent), 1);
        check("single_idle_busy", 32'(busy), 0);
        check("single_sb_empty", sb.size(), 0);

        // Back-to-back: second word lands while frame 1 shifts; no bubble.
        send(M1, E1);
        send(M2, E2);
        check("b2b_in_ready_drop", 32'(bus.in_ready), 0);
        run(-1, 0, -1, bc, vc);
        check("b2b_busy_cycles", bc, 19);
        check("b2b_valid_cycles", vc, 19);
        check("b2b_frames", 32'(frames_sent), 3);
        check("b2b_sb_empty", sb.size(), 0);

        // Backpressure at beat 4 for 3 cycles: 13 valid cycles.
        send(M1, E1);
        run(3, 3, -1, bc, vc);
        check("bp_valid_cycles", vc, 13);
        check("bp_busy_cycles", bc, 14);
        check("bp_frames_wrap", 32'(frames_sent), 0);
        check("bp_sb_empty", sb.size(), 0);

        // Reset while beat 6 is presented.
        send(M1, E1);
        run(-1, 0, 5, bc, vc);
        check("abort_mid_valid", 32'(bus.out_valid), 1);
        reset = 1'b0;
        #2;
        check_reset_outputs("abort");
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send(M1, E1);
        run(-1, 0, -1, bc, vc);
        check("post_abort_valid_cycles", vc, 10);
        check("post_abort_frames", 32'(frames_sent), 1);
        check("post_abort_sb_empty", sb.size(), 0);

        // Counter wrap on a 2-bit counter.
        reset = 1'b0;
        #2;
        check("wrap_reset_frames", 32'(frames_sent), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            send(M2, E2);
            run(-1, 0, -1, bc, vc);
            check("wrap_frames", 32'(frames_sent), 32'(exp_wrap[i]));
        end

        // msg_in churns while stalled by a full pending buffer.
        send(M1, E1);
        send(M2, E2);
        bus.in_valid = 1'b1;
        guard = 0;
        while (guard < 50) begin
            if (bus.in_ready) begin
                bus.msg_in = M3;
                push_frame(E3);
                @(posedge clk); #1;
                break;
            end
            bus.msg_in = M3 ^ 10'(guard + 1);
            guard++;
            @(posedge clk); #1;
        end
        check("churn_accepted", 32'(guard < 50), 1);
        bus.in_valid = 1'b0;
        bus.msg_in   = ~M3;
        run(-1, 0, -1, bc, vc);
        check("churn_frames", 32'(frames_sent), 0);
        check("churn_sb_empty", sb.size(), 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
